line_stream_packer: RTL and testbench

LINE_STREAM_PACKER -- requirements
Module: line_stream_packer

---
 rtl/line_stream_packer_if.sv | 31 +++
 rtl/line_stream_packer.sv | 140 ++++++++++++++
 tb/tb_line_stream_packer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_stream_packer_if.sv
// Per-flow FIFO handshake bundles used by line_stream_packer.
// read_interface : upstream FIFO side (empty/read/dout), one lane per flow.
// write_interface: downstream FIFO side (full/write/din), one lane per flow.
// The actor modport is the block that pops/pushes; master is the same view
// under the generic name, slave is the FIFO model side.

interface read_interface #(
    parameter int N = 2,
    parameter int W = 8
);
    logic [N-1:0] empty;
    logic [N-1:0] read;
    logic [W-1:0] dout [N];

    modport actor  (input empty, input dout, output read);
    modport master (input empty, input dout, output read);
    modport slave  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int N = 2,
    parameter int W = 8
);
    logic [N-1:0] full;
    logic [N-1:0] write;
    logic [W-1:0] din [N];

    modport actor  (input full, output write, output din);
    modport master (input full, output write, output din);
    modport slave  (output full, input write, input din);
endinterface

// File: rtl/line_stream_packer.sv
// line_stream_packer: per-flow block header / pel stream packer.
// Each flow accepts a {tag,height,width} header, forwards the sizes, then
// forwards width*height pels tagged with the flow index. One flow fires per
// cycle, lowest eligible index wins. Strobes are combinational in the firing
// cycle; all state is registered.
// Optional build macro: LINE_PACKER_ZERO_SKIP_EN -- when defined, headers with
// a zero width or height are popped and dropped without any size writes.

module line_stream_packer #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 18,
    parameter int SIZE_WIDTH = 7
) (
    input  logic          clk,
    input  logic          rst,
    read_interface.actor  read_port_hdr,
    read_interface.actor  read_port_pel,
    write_interface.actor write_port_ext_size,
    write_interface.actor write_port_real_size,
    write_interface.actor write_port_pel
);

    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int HDR_W     = 2 * SIZE_WIDTH + TAG_WIDTH;
    localparam int PEL_IN_W  = DATA_WIDTH + TAG_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state [FLUX];
    logic [SIZE_WIDTH-1:0] cnt_h [FLUX];
    logic [SIZE_WIDTH-1:0] cnt_v [FLUX];
    logic [SIZE_WIDTH-1:0] max_h [FLUX];
    logic [SIZE_WIDTH-1:0] max_v [FLUX];

    logic [SIZE_WIDTH-1:0] hdr_w [FLUX];
    logic [SIZE_WIDTH-1:0] hdr_h [FLUX];
    logic [FLUX-1:0]       hdr_zero;
    logic [FLUX-1:0]       is_idle;
    logic [FLUX-1:0]       eligible;
    logic [FLUX-1:0]       fire;

    // Incoming tags are deliberately ignored; the output tag is the lane index.
    logic [FLUX-1:0]       unused_hdr_tag;
    logic [FLUX-1:0]       unused_pel_tag;

    for (genvar i = 0; i < FLUX; i++) begin : g_flow
        assign hdr_w[i]          = read_port_hdr.dout[i][SIZE_WIDTH-1:0];
        assign hdr_h[i]          = read_port_hdr.dout[i][2*SIZE_WIDTH-1:SIZE_WIDTH];
        assign hdr_zero[i]       = (hdr_w[i] == '0) || (hdr_h[i] == '0);
        assign is_idle[i]        = (state[i] == IDLE);
        assign unused_hdr_tag[i] = ^read_port_hdr.dout[i][HDR_W-1:2*SIZE_WIDTH];
        assign unused_pel_tag[i] = ^read_port_pel.dout[i][PEL_IN_W-1:DATA_WIDTH];

        assign write_port_ext_size.din[i]  = {TAG_WIDTH'(i), hdr_h[i]};
        assign write_port_real_size.din[i] = {TAG_WIDTH'(i), hdr_w[i]};
        assign write_port_pel.din[i]       = {TAG_WIDTH'(i), read_port_pel.dout[i][DATA_WIDTH-1:0]};
    end

    // Per-flow eligibility: idle flows need a header and room for both sizes,
    // streaming flows need a pel and room for it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (is_idle[i]) begin
`ifdef LINE_PACKER_ZERO_SKIP_EN
                eligible[i] = !read_port_hdr.empty[i] &&
                              (hdr_zero[i] ||
                               (!write_port_ext_size.full[i] && !write_port_real_size.full[i]));
`else
                eligible[i] = !read_port_hdr.empty[i] &&
                              !write_port_ext_size.full[i] && !write_port_real_size.full[i];
`endif
            end else begin
                eligible[i] = !read_port_pel.empty[i] && !write_port_pel.full[i];
            end
        end
    end

    // Lowest set bit of eligible wins; nothing fires while in reset.
    assign fire = rst ? '0 : (eligible & (~eligible + FLUX'(1)));

    assign read_port_hdr.read  = fire & is_idle;
    assign read_port_pel.read  = fire & ~is_idle;
    assign write_port_pel.write = fire & ~is_idle;
`ifdef LINE_PACKER_ZERO_SKIP_EN
    assign write_port_ext_size.write  = fire & is_idle & ~hdr_zero;
    assign write_port_real_size.write = fire & is_idle & ~hdr_zero;
`else
    assign write_port_ext_size.write  = fire & is_idle;
    assign write_port_real_size.write = fire & is_idle;
`endif

    // Per-flow state machine and raster counters; only the fired flow moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                state[i] <= IDLE;
                cnt_h[i] <= '0;
                cnt_v[i] <= '0;
                max_h[i] <= '0;
                max_v[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                if (fire[i]) begin
                    if (is_idle[i]) begin
`ifdef LINE_PACKER_ZERO_SKIP_EN
                        if (!hdr_zero[i]) begin
                            max_h[i] <= hdr_w[i];
                            max_v[i] <= hdr_h[i];
                            cnt_h[i] <= '0;
                            cnt_v[i] <= '0;
                            state[i] <= STREAM;
                        end
`else
                        max_h[i] <= hdr_w[i];
                        max_v[i] <= hdr_h[i];
                        cnt_h[i] <= '0;
                        cnt_v[i] <= '0;
                        state[i] <= hdr_zero[i] ? IDLE : STREAM;
`endif
                    end else if (cnt_h[i] < (max_h[i] - SIZE_WIDTH'(1))) begin
                        cnt_h[i] <= cnt_h[i] + SIZE_WIDTH'(1);
                    end else if (cnt_v[i] < (max_v[i] - SIZE_WIDTH'(1))) begin
                        cnt_h[i] <= '0;
                        cnt_v[i] <= cnt_v[i] + SIZE_WIDTH'(1);
                    end else begin
                        cnt_h[i] <= '0;
                        cnt_v[i] <= '0;
                        state[i] <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_line_stream_packer.sv
// Bench for line_stream_packer (FLUX=2, DATA_WIDTH=18, SIZE_WIDTH=7).
// Sources are bench-side arrays; a block-level model (pels remaining per flow)
// predicts which flow fires each cycle and what it writes.
`timescale 1ns/1ps

module tb_line_stream_packer;

    localparam int FLUX      = 2;
    localparam int DW        = 18;
    localparam int SW        = 7;
    localparam int TW        = 1;
    localparam int HDR_W     = 2 * SW + TW;
    localparam int PEL_W     = DW + TW;
    localparam int SZ_W      = SW + TW;
    localparam int HDR_DEPTH = 64;
    localparam int PEL_DEPTH = 4400;
`ifdef LINE_PACKER_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    read_interface  #(.N(FLUX), .W(HDR_W)) hdr_if ();
    read_interface  #(.N(FLUX), .W(PEL_W)) pel_if ();
    write_interface #(.N(FLUX), .W(SZ_W))  ext_if ();
    write_interface #(.N(FLUX), .W(SZ_W))  real_if ();
    write_interface #(.N(FLUX), .W(PEL_W)) out_if ();

    line_stream_packer #(.FLUX(FLUX), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_port_hdr       (hdr_if),
        .read_port_pel       (pel_if),
        .write_port_ext_size (ext_if),
        .write_port_real_size(real_if),
        .write_port_pel      (out_if)
    );

    int            hdr_w_mem [FLUX][HDR_DEPTH];
    int            hdr_h_mem [FLUX][HDR_DEPTH];
    int            hdr_rd [FLUX];
    int            hdr_wr [FLUX];
    logic [DW-1:0] pel_mem [FLUX][PEL_DEPTH];
    int            pel_rd [FLUX];
    int            pel_wr [FLUX];
    logic [FLUX-1:0] ext_full, real_full, out_full;
    int            rem [FLUX];

    logic [SZ_W-1:0]  ext_log [$];
    logic [SZ_W-1:0]  real_log [$];
    logic [PEL_W-1:0] out_log [$];

    int tests    = 0;
    int failures = 0;
    int cycle    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    // Queue one header for flow f and its w*h pels with values base+k.
    task automatic applyStimulus(input int f, input int w, input int h, input int base);
        hdr_w_mem[f][hdr_wr[f]] = w;
        hdr_h_mem[f][hdr_wr[f]] = h;
        hdr_wr[f]++;
        for (int k = 0; k < w * h; k++) begin
            pel_mem[f][pel_wr[f]] = DW'(base + k);
            pel_wr[f]++;
        end
    endtask

    task automatic clearSources();
        for (int f = 0; f < FLUX; f++) begin
            hdr_rd[f] = 0; hdr_wr[f] = 0; pel_rd[f] = 0; pel_wr[f] = 0;
        end
        ext_log.delete(); real_log.delete(); out_log.delete();
    endtask

    task automatic driveInputs();
        for (int f = 0; f < FLUX; f++) begin
            hdr_if.empty[f] = (hdr_rd[f] == hdr_wr[f]);
            hdr_if.dout[f]  = {~TW'(f), SW'(hdr_h_mem[f][hdr_rd[f]]), SW'(hdr_w_mem[f][hdr_rd[f]])};
            pel_if.empty[f] = (pel_rd[f] == pel_wr[f]);
            pel_if.dout[f]  = {~TW'(f), pel_mem[f][pel_rd[f]]};
        end
        ext_if.full  = ext_full;
        real_if.full = real_full;
        out_if.full  = out_full;
    endtask

    // One cycle: drive at negedge, check strobes/data mid-cycle, advance model.
    task automatic tick();
        int ef, ew, eh;
        bit ez, elig, zero;
        logic [FLUX-1:0] e_hr, e_ew, e_rw, e_pr, e_pw;
        driveInputs();
        #2;
        ef = -1; ew = 0; eh = 0; ez = 1'b0;
        e_hr = '0; e_ew = '0; e_rw = '0; e_pr = '0; e_pw = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (ef < 0 && !rst) begin
                zero = (hdr_w_mem[f][hdr_rd[f]] == 0) || (hdr_h_mem[f][hdr_rd[f]] == 0);
                if (rem[f] == 0)
                    elig = (hdr_rd[f] != hdr_wr[f]) &&
                           ((SKIP && zero) || (!ext_full[f] && !real_full[f]));
                else
                    elig = (pel_rd[f] != pel_wr[f]) && !out_full[f];
                if (elig) begin
                    ef = f; ez = zero;
                    ew = hdr_w_mem[f][hdr_rd[f]];
                    eh = hdr_h_mem[f][hdr_rd[f]];
                end
            end
        end
        if (ef >= 0) begin
            if (rem[ef] == 0) begin
                e_hr[ef] = 1'b1;
                if (!(SKIP && ez)) begin e_ew[ef] = 1'b1; e_rw[ef] = 1'b1; end
            end else begin
                e_pr[ef] = 1'b1; e_pw[ef] = 1'b1;
            end
        end
        checkOutput("strobes", {hdr_if.read, ext_if.write, real_if.write, pel_if.read, out_if.write},
                    {e_hr, e_ew, e_rw, e_pr, e_pw});
        if (ef >= 0) begin
            if (e_ew[ef]) begin
                checkOutput("ext_din",  ext_if.din[ef],  {ef[0], SW'(eh)});
                checkOutput("real_din", real_if.din[ef], {ef[0], SW'(ew)});
            end
            if (e_pw[ef])
                checkOutput("pel_din", out_if.din[ef], {ef[0], pel_mem[ef][pel_rd[ef]]});
        end
        for (int f = 0; f < FLUX; f++) begin
            if (ext_if.write[f])  ext_log.push_back(ext_if.din[f]);
            if (real_if.write[f]) real_log.push_back(real_if.din[f]);
            if (out_if.write[f])  out_log.push_back(out_if.din[f]);
        end
        if (rst) begin
            for (int f = 0; f < FLUX; f++) rem[f] = 0;
        end else if (ef >= 0) begin
            if (rem[ef] == 0) begin
                hdr_rd[ef]++;
                rem[ef] = (SKIP && ez) ? 0 : ew * eh;
            end else begin
                pel_rd[ef]++;
                rem[ef]--;
            end
        end
        @(negedge clk);
        cycle++;
    endtask

    function automatic bit allDone();
        for (int f = 0; f < FLUX; f++)
            if (hdr_rd[f] != hdr_wr[f] || pel_rd[f] != pel_wr[f] || rem[f] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (!allDone() && n < max_cycles) begin tick(); n++; end
        tests++;
        if (!allDone()) begin
            failures++;
            $display("[TB] FAIL %s drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic tickUntilPels(input string name, input int count);
        int n = 0;
        while (out_log.size() < count && n < 100) begin tick(); n++; end
        checkOutput({name, "_reach"}, 64'(out_log.size()), 64'(count));
    endtask

    initial begin
        ext_full = '0; real_full = '0; out_full = '0;
        for (int f = 0; f < FLUX; f++) rem[f] = 0;
        clearSources();
        @(negedge clk);

        // Basic 3x2 block on flow0; the header waits through reset untouched.
        rst = 1'b1;
        applyStimulus(0, 3, 2, 100);
        repeat (3) tick();
        rst = 1'b0;
        drain("basic", 50);
        checkOutput("basic_ext_n",  64'(ext_log.size()), 64'd1);
        checkOutput("basic_ext",    ext_log[0],  8'h02);
        checkOutput("basic_real",   real_log[0], 8'h03);
        checkOutput("basic_pel_n",  64'(out_log.size()), 64'd6);
        checkOutput("basic_pel0",   out_log[0],  {1'b0, 18'd100});
        checkOutput("basic_pel5",   out_log[5],  {1'b0, 18'd105});

        // Both flows loaded: flow0 keeps priority, flow1 fills in afterwards.
        clearSources();
        applyStimulus(0, 2, 2, 200);
        applyStimulus(1, 1, 3, 300);
        drain("arb", 50);
        checkOutput("arb_ext0",  ext_log[0],  8'h02);
        checkOutput("arb_ext1",  ext_log[1],  8'h83);
        checkOutput("arb_real1", real_log[1], 8'h81);
        checkOutput("arb_pel3",  out_log[3],  {1'b0, 18'd203});
        checkOutput("arb_pel4",  out_log[4],  {1'b1, 18'd300});

        // Flow0 output blocked: flow1 gets the slots instead.
        clearSources();
        applyStimulus(0, 2, 2, 400);
        applyStimulus(1, 1, 3, 500);
        out_full = 2'b01;
        repeat (5) tick();
        out_full = '0;
        drain("block", 50);
        checkOutput("block_pel0", out_log[0], {1'b1, 18'd500});
        checkOutput("block_pel_n", 64'(out_log.size()), 64'd7);

        // Stall of 4 cycles after the second pel of a 4x4 block.
        clearSources();
        applyStimulus(0, 4, 4, 600);
        tickUntilPels("stall", 2);
        out_full = 2'b01;
        repeat (4) tick();
        checkOutput("stall_held", 64'(out_log.size()), 64'd2);
        out_full = '0;
        drain("stall", 50);
        checkOutput("stall_pel_n", 64'(out_log.size()), 64'd16);
        checkOutput("stall_pel2",  out_log[2],  {1'b0, 18'd602});
        checkOutput("stall_pel15", out_log[15], {1'b0, 18'd615});

        // Reset after pel 5 of a 4x4 block abandons it.
        clearSources();
        applyStimulus(0, 4, 4, 700);
        tickUntilPels("rst", 5);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("rst_no_pel", 64'(out_log.size()), 64'd5);
        pel_rd[0] = pel_wr[0];
        applyStimulus(0, 1, 1, 800);
        drain("rst", 20);
        checkOutput("rst_pel_n",  64'(out_log.size()), 64'd6);
        checkOutput("rst_newpel", out_log[5], {1'b0, 18'd800});

        // Zero-width header followed by a stray pel that must not be taken.
        clearSources();
        applyStimulus(0, 0, 5, 900);
        pel_mem[0][pel_wr[0]] = DW'(901);
        pel_wr[0]++;
        repeat (6) tick();
`ifdef LINE_PACKER_ZERO_SKIP_EN
        checkOutput("zero_ext_n", 64'(ext_log.size()), 64'd0);
`else
        checkOutput("zero_ext_n", 64'(ext_log.size()), 64'd1);
        checkOutput("zero_ext",   ext_log[0],  8'h05);
        checkOutput("zero_real",  real_log[0], 8'h00);
`endif
        checkOutput("zero_pel_n", 64'(out_log.size()), 64'd0);
        pel_rd[0] = pel_wr[0];

        // Largest block: 64x64 = 4096 pels, then back to idle.
        clearSources();
        applyStimulus(0, 64, 64, 0);
        drain("big", 4300);
        checkOutput("big_ext",     ext_log[0], 8'h40);
        checkOutput("big_pel_n",   64'(out_log.size()), 64'd4096);
        checkOutput("big_pel64",   out_log[64],   {1'b0, 18'd64});
        checkOutput("big_pel4095", out_log[4095], {1'b0, 18'd4095});
        pel_mem[0][pel_wr[0]] = DW'(7);
        pel_wr[0]++;
        repeat (4) tick();
        checkOutput("big_idle", 64'(out_log.size()), 64'd4096);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
